ezusb_tx_sched: RTL

Round-robin scheduler that shares the FPGA -> EZ-USB output stream (DI / DI_valid / DI_ready / pktend_arm of the slave-FIFO interface) between NCH independent 16-bit source channels. Each grant produces one burst: a header word, then up to MAX_BURST payload words from one channel. Frame ends (ch_last) trigger a manual PKTEND arm so that every frame is flushed to the host as a short packet. The block sits between the per-channel producers and the slave-FIFO interface block, in the ifclk domain.

---
 rtl/ezusb_tx_sched_if.sv | 38 +++
 rtl/ezusb_tx_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ezusb_tx_sched_if.sv
// Stream bundle between the per-channel producers, the round-robin
// scheduler and the slave-FIFO interface block (ifclk domain).
// The master side is the scheduler: it consumes channel words and
// drives the FIFO-facing DI stream and the PKTEND request.
interface ezusb_tx_sched_if #(
    parameter int unsigned NCH = 4
);
    logic [NCH*16-1:0] ch_data;
    logic [NCH-1:0]    ch_valid;
    logic [NCH-1:0]    ch_last;
    logic [NCH-1:0]    ch_ready;
    logic [15:0]       DI;
    logic              DI_valid;
    logic              DI_ready;
    logic              pktend_arm;

    modport master (
        input  ch_data,
        input  ch_valid,
        input  ch_last,
        output ch_ready,
        output DI,
        output DI_valid,
        input  DI_ready,
        output pktend_arm
    );

    modport slave (
        output ch_data,
        output ch_valid,
        output ch_last,
        input  ch_ready,
        input  DI,
        input  DI_valid,
        output DI_ready,
        input  pktend_arm
    );
endinterface

// File: rtl/ezusb_tx_sched.sv
// Round-robin scheduler sharing the FPGA -> EZ-USB output stream between
// NCH 16-bit source channels. Each grant emits a header word followed by
// up to MAX_BURST payload words; a frame end optionally arms PKTEND so the
// host sees every frame as a short packet.
module ezusb_tx_sched #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned MAX_BURST = 256,
    parameter bit          PKTEND_EN = 1'b1
) (
    input  logic                 ifclk,
    input  logic                 reset,
    input  logic                 en,
    ezusb_tx_sched_if.master     bus,
    output logic [3:0]           cur_ch,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_FLUSH
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic [3:0]      g;
    logic [3:0]      rr_ptr;
    logic [CW-1:0]   cnt;
    logic [NCH-1:0]  cont;

    logic [15:0]     valid16;
    logic            req_any;
    logic [3:0]      req_ch;
    logic            grant;

    logic [15:0]     sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic            cont_g;
    logic            xfer;
    logic            burst_end;

    assign valid16   = 16'(bus.ch_valid);
    assign grant     = (state == S_IDLE) && en && req_any;
    assign xfer      = (state == S_DATA) && sel_valid && bus.DI_ready;
    assign burst_end = (cnt == CW'(MAX_BURST - 1));
    assign cur_ch    = g;

    // Find the first requesting channel in cyclic order after rr_ptr.
    always_comb begin
        logic [4:0] idx;
        idx     = '0;
        req_any = 1'b0;
        req_ch  = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = {1'b0, rr_ptr} + 5'(i);
            if (idx >= 5'(NCH)) begin
                idx = idx - 5'(NCH);
            end
            if (!req_any && valid16[idx[3:0]]) begin
                req_any = 1'b1;
                req_ch  = idx[3:0];
            end
        end
    end

    // Route the granted channel's word, qualifiers and continuation flag.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        cont_g    = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (g == 4'(i)) begin
                sel_data  = bus.ch_data[16*i +: 16];
                sel_valid = bus.ch_valid[i];
                sel_last  = bus.ch_last[i];
                cont_g    = cont[i];
            end
        end
    end

    // State register; reset aborts any burst without a PKTEND request.
    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decision. A frame end takes priority over the burst limit.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (grant) begin
                    state_nx = S_HEADER;
                end
            end
            S_HEADER: begin
                if (bus.DI_ready) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    if (sel_last) begin
                        state_nx = PKTEND_EN ? S_FLUSH : S_IDLE;
                    end else if (burst_end) begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, burst word counter and per-channel continuation flags.
    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            g      <= '0;
            rr_ptr <= 4'(NCH - 1);
            cnt    <= '0;
            cont   <= '0;
        end else begin
            if (grant) begin
                g      <= req_ch;
                rr_ptr <= req_ch;
                cnt    <= '0;
            end
            if (xfer) begin
                cnt <= cnt + 1'b1;
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (g == 4'(i)) begin
                        if (sel_last) begin
                            cont[i] <= 1'b0;
                        end else if (burst_end) begin
                            cont[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Stream outputs: header from registered state, payload passed through.
    always_comb begin
        bus.DI         = '0;
        bus.DI_valid   = 1'b0;
        bus.ch_ready   = '0;
        bus.pktend_arm = 1'b0;
        busy           = (state != S_IDLE);
        unique case (state)
            S_HEADER: begin
                bus.DI       = {4'hA, g, cont_g, 7'b0};
                bus.DI_valid = 1'b1;
            end
            S_DATA: begin
                bus.DI       = sel_data;
                bus.DI_valid = sel_valid;
                for (int unsigned i = 0; i < NCH; i++) begin
                    bus.ch_ready[i] = (g == 4'(i)) && bus.DI_ready;
                end
            end
            S_FLUSH: begin
                bus.pktend_arm = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
